// File: rtl/mips_run_controller.sv
// mips_run_controller: run sequencer and checker for a MIPS CPU under test.
// The controller resets the CPU and confirms that it becomes active. It then
// clocks the CPU until active falls, a timeout occurs or a data port conflict
// is seen. On entry to DONE it captures v0 and latches the reason for stopping.
// Optional build macro: MIPS_RUN_PAUSE_EN adds a 'pause' input. While pause is
// high in RUN, the CPU clock enable is dropped, the cycle counter holds and all
// checks are suspended.
module mips_run_controller #(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int RESET_CYCLES   = 1,
  parameter int N_PORTS        = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               cpu_reset,
  output logic               cpu_clk_enable,
  input  logic               cpu_active,
  input  logic [DATA_W-1:0]  cpu_register_v0,
  input  logic [N_PORTS-1:0] mem_read,
  input  logic [N_PORTS-1:0] mem_write,
`ifdef MIPS_RUN_PAUSE_EN
  input  logic               pause,
`endif
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               err_timeout,
  output logic               err_no_active,
  output logic [N_PORTS-1:0] err_conflict
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  // A timeout that the counter cannot reach, or an empty reset pulse, is a build error.
  if (TIMEOUT_CYCLES < 1 || (CNT_W < 31 && TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_timeout
    $error("mips_run_controller: TIMEOUT_CYCLES must be >= 1 and < 2**CNT_W");
  end
  if (RESET_CYCLES < 1) begin : g_bad_reset
    $error("mips_run_controller: RESET_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    CHECK,
    RUN,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [RST_W-1:0]   rst_cnt, rst_cnt_nxt;
  logic [DATA_W-1:0]  result_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic [CNT_W-1:0]   count_inc;
  logic               err_timeout_nxt;
  logic               err_no_active_nxt;
  logic [N_PORTS-1:0] err_conflict_nxt;
  logic [N_PORTS-1:0] conflict_bits;
  logic               run_paused;
  logic               run_hold;

`ifdef MIPS_RUN_PAUSE_EN
  assign run_paused = pause;
`else
  assign run_paused = 1'b0;
`endif

  assign run_hold      = (state == RUN) && run_paused;
  assign conflict_bits = mem_read & mem_write;
  assign count_inc     = cycle_count + CNT_W'(1);

  // Next-state, counter and capture logic; everything holds unless a rule fires.
  always_comb begin
    state_nxt         = state;
    rst_cnt_nxt       = rst_cnt;
    result_nxt        = result;
    count_nxt         = cycle_count;
    err_timeout_nxt   = err_timeout;
    err_no_active_nxt = err_no_active;
    err_conflict_nxt  = err_conflict;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt         = RESET;
          rst_cnt_nxt       = '0;
          result_nxt        = '0;
          count_nxt         = '0;
          err_timeout_nxt   = 1'b0;
          err_no_active_nxt = 1'b0;
          err_conflict_nxt  = '0;
        end
      end
      RESET: begin
        if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
          state_nxt = CHECK;
        end else begin
          rst_cnt_nxt = rst_cnt + RST_W'(1);
        end
      end
      CHECK: begin
        count_nxt = '0;
        if (!cpu_active) begin
          err_no_active_nxt = 1'b1;
          result_nxt        = cpu_register_v0;
          state_nxt         = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!run_paused) begin
          count_nxt = count_inc;
          if (|conflict_bits) begin
            err_conflict_nxt = err_conflict | conflict_bits;
            result_nxt       = cpu_register_v0;
            state_nxt        = DONE;
          end else if (!cpu_active) begin
            result_nxt = cpu_register_v0;
            state_nxt  = DONE;
          end else if (count_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            err_timeout_nxt = 1'b1;
            result_nxt      = cpu_register_v0;
            state_nxt       = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; status outputs are decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rst_cnt        <= '0;
      result         <= '0;
      cycle_count    <= '0;
      err_timeout    <= 1'b0;
      err_no_active  <= 1'b0;
      err_conflict   <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      cpu_reset      <= 1'b0;
      cpu_clk_enable <= 1'b0;
    end else begin
      state          <= state_nxt;
      rst_cnt        <= rst_cnt_nxt;
      result         <= result_nxt;
      cycle_count    <= count_nxt;
      err_timeout    <= err_timeout_nxt;
      err_no_active  <= err_no_active_nxt;
      err_conflict   <= err_conflict_nxt;
      busy           <= (state_nxt == RESET) || (state_nxt == CHECK) || (state_nxt == RUN);
      done           <= (state_nxt == DONE);
      cpu_reset      <= (state_nxt == RESET);
      cpu_clk_enable <= (state_nxt == CHECK) || ((state_nxt == RUN) && !run_hold);
    end
  end

endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller: randomized runs of mips_run_controller checked every
// cycle against a timeline model derived from each run's scenario.
module tb_mips_run_controller;

  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int TMO = 20;
  localparam int R   = 2;
  localparam int NP  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          cpu_reset;
  logic          cpu_clk_enable;
  logic          cpu_active = 1'b0;
  logic [DW-1:0] cpu_register_v0 = '0;
  logic [NP-1:0] mem_read = '0;
  logic [NP-1:0] mem_write = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic [CW-1:0] cycle_count;
  logic          err_timeout;
  logic          err_no_active;
  logic [NP-1:0] err_conflict;
`ifdef MIPS_RUN_PAUSE_EN
  logic          pause = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Model expectations for the cycle following the most recent rising edge
  logic          cmp_en = 1'b1;
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic          exp_rst = 1'b0;
  logic          exp_ce = 1'b0;
  logic [DW-1:0] exp_result = '0;
  int            exp_count = 0;
  logic          exp_to = 1'b0;
  logic          exp_na = 1'b0;
  logic [NP-1:0] exp_cf = '0;

  mips_run_controller #(
    .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(TMO), .RESET_CYCLES(R), .N_PORTS(NP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .cpu_reset(cpu_reset),
    .cpu_clk_enable(cpu_clk_enable),
    .cpu_active(cpu_active),
    .cpu_register_v0(cpu_register_v0),
    .mem_read(mem_read),
    .mem_write(mem_write),
`ifdef MIPS_RUN_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy),
    .done(done),
    .result(result),
    .cycle_count(cycle_count),
    .err_timeout(err_timeout),
    .err_no_active(err_no_active),
    .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("busy", 64'(busy), 64'(exp_busy));
      checkOutput("done", 64'(done), 64'(exp_done));
      checkOutput("cpu_reset", 64'(cpu_reset), 64'(exp_rst));
      checkOutput("cpu_clk_enable", 64'(cpu_clk_enable), 64'(exp_ce));
      checkOutput("result", 64'(result), 64'(exp_result));
      checkOutput("cycle_count", 64'(cycle_count), 64'(exp_count));
      checkOutput("err_timeout", 64'(err_timeout), 64'(exp_to));
      checkOutput("err_no_active", 64'(err_no_active), 64'(exp_na));
      checkOutput("err_conflict", 64'(err_conflict), 64'(exp_cf));
    end
  end

  function automatic void clearExpect();
    exp_busy = 1'b0; exp_done = 1'b0; exp_rst = 1'b0; exp_ce = 1'b0;
    exp_result = '0; exp_count = 0; exp_to = 1'b0; exp_na = 1'b0; exp_cf = '0;
  endfunction

  // One run: k = RUN cycle from which active is low (0 = never), c = RUN cycle
  // with a conflict (0 = none), no_act = active low at CHECK, abort_at = RUN
  // cycle at which reset_n is pulled (0 = none). Post-edge n counts from the
  // edge that samples start; RESET spans n<R, CHECK is n==R, RUN cycle j is n==R+j.
  task automatic applyStimulus(input int k, input int c, input logic [NP-1:0] cmask,
                               input bit no_act, input int idle_after,
                               input int abort_at, input bit fix_v0);
    int e, done_n, j;
    logic [DW-1:0] v0_end;
    logic [NP-1:0] rr, ww;
    logic f_to, f_na;
    logic [NP-1:0] f_cf;
    e = TMO;
    if (k > 0 && k < e) e = k;
    if (c > 0 && c <= e) e = c;
    done_n = no_act ? R + 1 : R + 1 + e;
    f_na = no_act;
    f_cf = (!no_act && c == e) ? cmask : '0;
    f_to = !no_act && (c != e) && !(k > 0 && k == e);
    v0_end = '0;
    start = 1'b1;
    for (int n = 0; n <= done_n + idle_after; n++) begin
      @(posedge clk); #1;
      j = n - R;
      exp_rst    = (n < R);
      exp_busy   = (n < done_n);
      exp_done   = (n >= done_n);
      exp_ce     = (n >= R) && (n < done_n);
      exp_count  = (n >= done_n) ? (no_act ? 0 : e) : ((j >= 1) ? j - 1 : 0);
      exp_result = (n >= done_n) ? v0_end : '0;
      exp_to     = (n >= done_n) ? f_to : 1'b0;
      exp_na     = (n >= done_n) ? f_na : 1'b0;
      exp_cf     = (n >= done_n) ? f_cf : '0;
      if (abort_at > 0 && !no_act && j == abort_at && j <= e) begin
        cmp_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_cpu_reset", 64'(cpu_reset), 64'd0);
        checkOutput("abort_cpu_clk_enable", 64'(cpu_clk_enable), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_cycle_count", 64'(cycle_count), 64'd0);
        start = 1'b0;
        clearExpect();
        @(posedge clk); #3;
        reset_n = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (n == done_n + idle_after) break;
      start = (n < done_n) ? 1'($urandom_range(0, 1)) : 1'b0;
      cpu_register_v0 = fix_v0 ? 32'h0000_002A : DW'($urandom);
      if (n == R + (no_act ? 0 : e)) v0_end = cpu_register_v0;
      rr = NP'($urandom);
      ww = NP'($urandom);
      if (n == R) cpu_active = !no_act;
      else if (n > R && n < done_n) cpu_active = !(k > 0 && j >= k);
      else cpu_active = 1'($urandom);
      if (n > R && n < done_n) begin
        if (j == c) begin
          mem_read  = cmask | (rr & ~cmask);
          mem_write = cmask | (ww & ~rr & ~cmask);
        end else begin
          mem_read  = rr;
          mem_write = ww & ~rr;
        end
      end else begin
        mem_read  = rr;
        mem_write = ww;
      end
    end
  endtask

  initial begin
    int k, c;
    logic [NP-1:0] cm;
    bit na;
    clearExpect();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Normal completion with active low from RUN cycle 7
    applyStimulus(7, 0, '0, 1'b0, 2, 0, 1'b1);
    checkOutput("normal_done", 64'(done), 64'd1);
    checkOutput("normal_result", 64'(result), 64'h2A);
    checkOutput("normal_count", 64'(cycle_count), 64'd7);
    checkOutput("normal_errs", 64'({err_timeout, err_no_active, err_conflict}), 64'd0);

    // Active never falls
    applyStimulus(0, 0, '0, 1'b0, 1, 0, 1'b0);
    checkOutput("timeout_flag", 64'(err_timeout), 64'd1);
    checkOutput("timeout_count", 64'(cycle_count), 64'd20);

    // Active low at CHECK, back-to-back start afterwards
    applyStimulus(0, 0, '0, 1'b1, 0, 0, 1'b0);
    checkOutput("noactive_flag", 64'(err_no_active), 64'd1);
    checkOutput("noactive_count", 64'(cycle_count), 64'd0);

    // Conflict on port 1 in the same cycle that active falls
    applyStimulus(3, 3, 2'b10, 1'b0, 1, 0, 1'b1);
    checkOutput("conflict_bits", 64'(err_conflict), 64'b10);
    checkOutput("conflict_result", 64'(result), 64'h2A);
    checkOutput("conflict_count", 64'(cycle_count), 64'd3);
    checkOutput("conflict_timeout", 64'(err_timeout), 64'd0);

    // Reset pulled at RUN cycle 5, then a fresh normal run
    applyStimulus(0, 0, '0, 1'b0, 0, 5, 1'b0);
    applyStimulus(7, 0, '0, 1'b0, 1, 0, 1'b1);
    checkOutput("after_abort_result", 64'(result), 64'h2A);
    checkOutput("after_abort_count", 64'(cycle_count), 64'd7);

    for (int r = 0; r < 40; r++) begin
      k  = $urandom_range(0, 24);
      c  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 22) : 0;
      cm = NP'($urandom_range(1, 3));
      na = ($urandom_range(0, 9) == 0);
      applyStimulus(k, c, cm, na, $urandom_range(0, 3), 0, 1'b0);
    end

    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
